// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: per-bit synchroniser, optional debounce and sticky
// edge-detect pending flags ORed onto a single interrupt line.
module gpio_in_cond #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [WIDTH-1:0]    PAD_IN,
  input  logic [WIDTH-1:0]    DB_EN,
  input  logic [DB_CNT_W-1:0] DB_LIMIT,
  input  logic [WIDTH-1:0]    IRQ_RISE_EN,
  input  logic [WIDTH-1:0]    IRQ_FALL_EN,
  input  logic [WIDTH-1:0]    IRQ_CLR,
  output logic [WIDTH-1:0]    GPIO_IN,
  output logic [WIDTH-1:0]    IRQ_PEND,
  output logic                IRQ
);

  logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]    sync_w;
  logic [WIDTH-1:0]    s_q;
  logic [WIDTH-1:0]    s_next;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    fall;
  logic [WIDTH-1:0]    pend_q;
  logic [DB_CNT_W-1:0] cnt_q    [WIDTH];
  logic [DB_CNT_W-1:0] cnt_next [WIDTH];

  // Plain flop chain: nothing may sit between stages or metastability leaks through.
  // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= PAD_IN;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Counter only runs while the synchronised value disagrees with the stable value.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      s_next[i]   = s_q[i];
      cnt_next[i] = '0;
      if (sync_w[i] != s_q[i]) begin
        if (!DB_EN[i] || (cnt_q[i] >= DB_LIMIT)) begin
          s_next[i] = sync_w[i];
        end else begin
          cnt_next[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = s_next & ~s_q;
  assign fall = ~s_next & s_q;

  // NOTE: the counter array is state with a defined reset value, so it is cleared like any register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s_q <= s_next;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_next[i];
    end
  end

  // A new edge takes priority over a clear arriving in the same cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~IRQ_CLR)
              | (rise & IRQ_RISE_EN)
              | (fall & IRQ_FALL_EN);
    end
  end

  assign GPIO_IN  = s_q;
  assign IRQ_PEND = pend_q;
  assign IRQ      = |pend_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Self-checking bench for gpio_in_cond: latency/glitch tables, directed interrupt
// and reset sequences, then randomized traffic against a history-based reference model.
module tb_gpio_in_cond;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int CW = 16;
  localparam int HL = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [W-1:0]  PAD_IN, DB_EN, IRQ_RISE_EN, IRQ_FALL_EN, IRQ_CLR;
  logic [CW-1:0] DB_LIMIT;
  logic [W-1:0]  GPIO_IN, IRQ_PEND;
  logic          IRQ;

  gpio_in_cond #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CNT_W(CW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PAD_IN(PAD_IN), .DB_EN(DB_EN),
    .DB_LIMIT(DB_LIMIT), .IRQ_RISE_EN(IRQ_RISE_EN), .IRQ_FALL_EN(IRQ_FALL_EN),
    .IRQ_CLR(IRQ_CLR), .GPIO_IN(GPIO_IN), .IRQ_PEND(IRQ_PEND), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the stable value follows the synchronised pad once it has
  // disagreed for more than DB_LIMIT consecutive samples (or at once without debounce).
  logic [W-1:0] padh [HL];
  logic [W-1:0] m_s, m_ns, m_pend;
  int           streak;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int k = 0; k < HL; k++) padh[k] = '0;
      m_s    = '0;
      m_pend = '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        m_ns[i] = m_s[i];
        if (padh[SS-1][i] != m_s[i]) begin
          streak = 0;
          while (streak <= int'(DB_LIMIT) && (SS - 1 + streak) < HL
                 && padh[SS-1+streak][i] != m_s[i])
            streak++;
          if (!DB_EN[i] || streak > int'(DB_LIMIT)) m_ns[i] = padh[SS-1][i];
        end
      end
      m_pend = (m_pend & ~IRQ_CLR) | (m_ns & ~m_s & IRQ_RISE_EN) | (~m_ns & m_s & IRQ_FALL_EN);
      m_s    = m_ns;
      for (int k = HL - 1; k > 0; k--) padh[k] = padh[k-1];
      padh[0] = PAD_IN;
    end
  end

  typedef struct {
    logic db_en;
    int   limit;
    int   exp_lat;
  } lat_vec_t;

  typedef struct {
    int   limit;
    int   pulse_len;
    logic exp_seen;
  } glitch_vec_t;

  lat_vec_t    lat_tab    [6];
  glitch_vec_t glitch_tab [4];

  task automatic clear_inputs();
    PAD_IN = '0; DB_EN = '0; DB_LIMIT = '0;
    IRQ_RISE_EN = '0; IRQ_FALL_EN = '0; IRQ_CLR = '0;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    clear_inputs();
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic seen;

    lat_tab[0] = '{1'b0, 0, 3};
    lat_tab[1] = '{1'b0, 5, 3};
    lat_tab[2] = '{1'b1, 0, 3};
    lat_tab[3] = '{1'b1, 1, 4};
    lat_tab[4] = '{1'b1, 4, 7};
    lat_tab[5] = '{1'b1, 9, 12};

    glitch_tab[0] = '{4, 4, 1'b0};
    glitch_tab[1] = '{4, 5, 1'b1};
    glitch_tab[2] = '{2, 2, 1'b0};
    glitch_tab[3] = '{2, 3, 1'b1};

    // Reset state, observed with no clock edge after assertion.
    clear_inputs();
    HRESET = 1'b1;
    #1;
    check("reset gpio_in", GPIO_IN, '0);
    check("reset irq_pend", IRQ_PEND, '0);
    check("reset irq", IRQ, 1'b0);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    // Pad-to-GPIO_IN latency for several debounce settings.
    foreach (lat_tab[t]) begin
      do_reset();
      DB_EN[0] = lat_tab[t].db_en;
      DB_LIMIT = CW'(lat_tab[t].limit);
      repeat (2) @(negedge HCLK);
      PAD_IN[0] = 1'b1;
      lat = 0;
      while (!GPIO_IN[0] && lat < 40) begin
        @(negedge HCLK);
        lat++;
      end
      check($sformatf("latency db_en=%0d limit=%0d", lat_tab[t].db_en, lat_tab[t].limit),
            lat, lat_tab[t].exp_lat);
    end

    // Glitch rejection on bit 3.
    foreach (glitch_tab[t]) begin
      do_reset();
      DB_EN[3] = 1'b1;
      DB_LIMIT = CW'(glitch_tab[t].limit);
      repeat (2) @(negedge HCLK);
      PAD_IN[3] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < glitch_tab[t].pulse_len + glitch_tab[t].limit + 10; c++) begin
        if (c == glitch_tab[t].pulse_len) PAD_IN[3] = 1'b0;
        @(negedge HCLK);
        seen |= GPIO_IN[3];
      end
      check($sformatf("glitch limit=%0d len=%0d", glitch_tab[t].limit, glitch_tab[t].pulse_len),
            seen, glitch_tab[t].exp_seen);
    end

    // Rising-edge interrupt on bit 5; fall not enabled; W1C clear.
    do_reset();
    IRQ_RISE_EN[5] = 1'b1;
    repeat (2) @(negedge HCLK);
    PAD_IN[5] = 1'b1;
    lat = 0;
    while (!GPIO_IN[5] && lat < 10) begin
      check("rise pend before gpio", IRQ_PEND[5], 1'b0);
      @(negedge HCLK);
      lat++;
    end
    check("rise latency", lat, 3);
    check("rise pend with gpio", IRQ_PEND[5], 1'b1);
    check("rise irq with gpio", IRQ, 1'b1);
    PAD_IN[5] = 1'b0;
    repeat (6) @(negedge HCLK);
    check("fall gpio", GPIO_IN[5], 1'b0);
    check("fall not enabled pend", IRQ_PEND, 32'h0000_0020);
    IRQ_CLR[5] = 1'b1;
    @(negedge HCLK);
    IRQ_CLR = '0;
    check("clear irq", IRQ, 1'b0);
    check("clear pend", IRQ_PEND, '0);

    // Falling edge on bit 7 with a simultaneous clear: set wins.
    do_reset();
    IRQ_FALL_EN[7] = 1'b1;
    PAD_IN[7] = 1'b1;
    repeat (6) @(negedge HCLK);
    check("fall7 high gpio", GPIO_IN[7], 1'b1);
    check("fall7 rise not enabled", IRQ_PEND, '0);
    PAD_IN[7] = 1'b0;
    repeat (2) @(negedge HCLK);
    check("fall7 before land", GPIO_IN[7], 1'b1);
    IRQ_CLR[7] = 1'b1;
    @(negedge HCLK);
    IRQ_CLR = '0;
    check("fall7 landed", GPIO_IN[7], 1'b0);
    check("fall7 set beats clear", IRQ_PEND[7], 1'b1);
    check("fall7 irq", IRQ, 1'b1);

    // Lowering DB_LIMIT below a live count accepts on the next cycle.
    do_reset();
    DB_EN[2] = 1'b1;
    DB_LIMIT = 16'd100;
    repeat (2) @(negedge HCLK);
    PAD_IN[2] = 1'b1;
    repeat (52) @(negedge HCLK);
    check("limit drop before", GPIO_IN[2], 1'b0);
    DB_LIMIT = 16'd10;
    @(negedge HCLK);
    check("limit drop after", GPIO_IN[2], 1'b1);

    // Asynchronous reset mid-count with a pending flag, then pad high through release.
    do_reset();
    IRQ_RISE_EN[5] = 1'b1;
    DB_EN[3] = 1'b1;
    DB_LIMIT = 16'd50;
    repeat (2) @(negedge HCLK);
    PAD_IN[5] = 1'b1;
    PAD_IN[3] = 1'b1;
    repeat (10) @(negedge HCLK);
    check("pre-reset pend", IRQ_PEND[5], 1'b1);
    #2 HRESET = 1'b1;
    #1;
    check("async reset gpio_in", GPIO_IN, '0);
    check("async reset pend", IRQ_PEND, '0);
    check("async reset irq", IRQ, 1'b0);
    clear_inputs();
    PAD_IN[1] = 1'b1;
    IRQ_RISE_EN[1] = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);
    check("post-reset pend early", IRQ_PEND, '0);
    @(negedge HCLK);
    check("post-reset pend", IRQ_PEND, 32'h0000_0002);
    check("post-reset gpio", GPIO_IN, 32'h0000_0002);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge HCLK);
      check("rand gpio_in", GPIO_IN, m_s);
      check("rand irq_pend", IRQ_PEND, m_pend);
      check("rand irq", IRQ, |m_pend);
      if (c % 250 == 0) begin
        DB_EN       = $urandom;
        DB_LIMIT    = CW'($urandom_range(0, 6));
        IRQ_RISE_EN = $urandom;
        IRQ_FALL_EN = $urandom;
      end
      PAD_IN  = PAD_IN ^ ($urandom & $urandom & $urandom & $urandom);
      IRQ_CLR = $urandom & $urandom & $urandom;
      if (c == 1500) begin
        #2 HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
